// File: rtl/tri_dispatch_ctrl.sv
// Round-robin dispatcher: two triangle sources share one rasterizer over valid/ack; optional ack watchdog under TRI_DISPATCH_TIMEOUT_EN.
// Latency: ready seen in IDLE -> tri_valid 2 cycles later; triangle held until rast_ack, 3 cycles minimum per triangle.
module tri_dispatch_ctrl #(
  parameter int DATA_W      = 96,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s0_ready,
  input  logic [6*DATA_W-1:0] s0_tri,
  output logic                s0_dequeue,
  input  logic                s1_ready,
  input  logic [6*DATA_W-1:0] s1_tri,
  output logic                s1_dequeue,
  output logic                tri_valid,
  output logic [3*DATA_W-1:0] tri_vtx,
  output logic [3*DATA_W-1:0] tri_col,
  output logic                tri_src,
  input  logic                rast_ack,
  output logic [CNT_W-1:0]    tri_count,
  output logic                timeout_err
);

  localparam int TRI_W = 3*DATA_W;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DISPATCH = 2'd2} state_e;

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               tri_src_q, tri_src_d;
  logic               s0_deq_q, s0_deq_d;
  logic               s1_deq_q, s1_deq_d;
  logic               tri_valid_q, tri_valid_d;
  logic [TRI_W-1:0]   tri_vtx_q, tri_vtx_d;
  logic [TRI_W-1:0]   tri_col_q, tri_col_d;
  logic [CNT_W-1:0]   tri_count_q, tri_count_d;
  logic [2*TRI_W-1:0] sel_tri;

  assign sel_tri = grant_q ? s1_tri : s0_tri;

`ifdef TRI_DISPATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic            to_hit;

  // Last un-acked DISPATCH cycle: the increment here would reach the limit.
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tri_src_d    = tri_src_q;
    s0_deq_d     = s0_deq_q;
    s1_deq_d     = s1_deq_q;
    tri_valid_d  = tri_valid_q;
    tri_vtx_d    = tri_vtx_q;
    tri_col_d    = tri_col_q;
    tri_count_d  = tri_count_q;
`ifdef TRI_DISPATCH_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (s0_ready || s1_ready) begin
          // Contention goes to whichever source was not served last.
          grant_d = (s0_ready && s1_ready) ? ~last_grant_q : s1_ready;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tri_vtx_d   = sel_tri[TRI_W-1:0];
        tri_col_d   = sel_tri[2*TRI_W-1:TRI_W];
        tri_src_d   = grant_q;
        s0_deq_d    = ~grant_q;
        s1_deq_d    = grant_q;
        tri_valid_d = 1'b1;
        state_d     = DISPATCH;
`ifdef TRI_DISPATCH_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
      end
      DISPATCH: begin
        s0_deq_d = 1'b0;
        s1_deq_d = 1'b0;
        if (rast_ack) begin
          tri_valid_d  = 1'b0;
          tri_count_d  = tri_count_q + 1'b1;
          last_grant_d = tri_src_q;
          state_d      = IDLE;
        end
`ifdef TRI_DISPATCH_TIMEOUT_EN
        else if (to_hit) begin
          tri_valid_d   = 1'b0;
          timeout_err_d = 1'b1;
          last_grant_d  = tri_src_q;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tri_src_q    <= 1'b0;
      s0_deq_q     <= 1'b0;
      s1_deq_q     <= 1'b0;
      tri_valid_q  <= 1'b0;
      tri_vtx_q    <= '0;
      tri_col_q    <= '0;
      tri_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tri_src_q    <= tri_src_d;
      s0_deq_q     <= s0_deq_d;
      s1_deq_q     <= s1_deq_d;
      tri_valid_q  <= tri_valid_d;
      tri_vtx_q    <= tri_vtx_d;
      tri_col_q    <= tri_col_d;
      tri_count_q  <= tri_count_d;
    end
  end

`ifdef TRI_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // No watchdog in this build: the flag can never rise, the limit only keeps the interface identical.
  assign timeout_err = (TIMEOUT_CYC < 0);
`endif

  assign s0_dequeue = s0_deq_q;
  assign s1_dequeue = s1_deq_q;
  assign tri_valid  = tri_valid_q;
  assign tri_vtx    = tri_vtx_q;
  assign tri_col    = tri_col_q;
  assign tri_src    = tri_src_q;
  assign tri_count  = tri_count_q;

endmodule
